// File: rtl/tmds_channel_decoder.sv
// Purpose: word alignment and TMDS decode for one DVI/TMDS sink channel.
// Latency: 1 cycle from the aligned word to the registered data/de/ctrl/out_valid outputs.
// Backpressure: none. raw_valid=0 freezes state, counters and outputs, and forces out_valid=0.
// Ports: clk, reset (synchronous, active-high); raw_valid/raw_word come from the deserializer
//        (bit 0 is received first); data/de/ctrl/out_valid carry the decoded word;
//        locked/offset report the alignment status.
module tmds_channel_decoder #(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_valid,
  input  logic [9:0] raw_word,
  output logic [7:0] data,
  output logic       de,
  output logic [1:0] ctrl,
  output logic       out_valid,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
  localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [9:0]        prev_q, prev_d;
  logic [3:0]        offset_q, offset_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [7:0]        data_q, data_d;
  logic              de_q, de_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              out_valid_q, out_valid_d;

  // The largest offset (9) reaches bit 18, so raw_word[9] never enters the window.
  logic [18:0] window;
  logic [9:0]  aligned;
  logic        is_tok;
  logic [1:0]  tok_c;
  logic [7:0]  t_byte;
  logic [7:0]  dec_byte;
  logic        lock_hit;
  logic        loss_hit;

  // Older bits sit at the low end, so a higher offset skips further into the stream.
  always_comb begin
    window  = {raw_word[8:0], prev_q};
    aligned = window[9:0];
    for (int o = 1; o < 10; o++) begin
      if (offset_q == 4'(o)) aligned = window[o +: 10];
    end
  end

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (aligned)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
  always_comb begin
    t_byte      = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec_byte    = 8'h00;
    dec_byte[0] = t_byte[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = aligned[8] ? (t_byte[i] ^ t_byte[i-1]) : ~(t_byte[i] ^ t_byte[i-1]);
    end
  end

  assign lock_hit = is_tok && (run_q == RUN_LAST);
  assign loss_hit = !is_tok && (loss_q == LOSS_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_SEARCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (raw_valid) begin
      case (state_q)
        S_SEARCH: if (lock_hit) state_d = S_LOCKED;
        S_LOCKED: if (loss_hit) state_d = S_SEARCH;
        default:  state_d = S_SEARCH;
      endcase
    end
  end

  // Counters and decoded outputs
  always_comb begin
    prev_d      = prev_q;
    offset_d    = offset_q;
    run_d       = run_q;
    win_d       = win_q;
    loss_d      = loss_q;
    data_d      = data_q;
    de_d        = de_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    if (raw_valid) begin
      prev_d = raw_word;
      case (state_q)
        S_SEARCH: begin
          de_d   = 1'b0;
          data_d = 8'h00;
          loss_d = '0;
          if (lock_hit) begin
            // Lock takes priority over window expiry, so the offset stays put.
            run_d = '0;
            win_d = '0;
          end else if (win_q == WIN_LAST) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            run_d    = '0;
            win_d    = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
            run_d = is_tok ? run_q + RUN_W'(1) : '0;
          end
        end
        S_LOCKED: begin
          if (is_tok) begin
            de_d        = 1'b0;
            ctrl_d      = tok_c;
            loss_d      = '0;
            out_valid_d = 1'b1;
          end else if (loss_hit) begin
            // The word that drops lock is swallowed and the search resumes at this offset.
            de_d   = 1'b0;
            data_d = 8'h00;
            loss_d = '0;
            run_d  = '0;
            win_d  = '0;
          end else begin
            de_d        = 1'b1;
            data_d      = dec_byte;
            loss_d      = loss_q + LOSS_W'(1);
            out_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= 10'h000;
      offset_q    <= 4'd0;
      run_q       <= '0;
      win_q       <= '0;
      loss_q      <= '0;
      data_q      <= 8'h00;
      de_q        <= 1'b0;
      ctrl_q      <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      offset_q    <= offset_d;
      run_q       <= run_d;
      win_q       <= win_d;
      loss_q      <= loss_d;
      data_q      <= data_d;
      de_q        <= de_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data      = data_q;
  assign de        = de_q;
  assign ctrl      = ctrl_q;
  assign out_valid = out_valid_q;
  assign locked    = (state_q == S_LOCKED);
  assign offset    = offset_q;

endmodule
